alu_8bit: RTL and testbench
===========================

ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 8-bit operands and a 16-bit result.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 code  in  18  [17:10]=X operand, [9:2]=Y operand, [1:0]=op (00 add, 01 sub, 10 signed Booth mul, 11 unsigned non-restoring div).
REQ-005 rez  out  16  registered result.
REQ-006 flag_zero  out  1  registered; high when rez written as 0.
REQ-007 flag_overflow  out  1  registered; signed add/sub overflow or divide-by-zero.
REQ-008 A  out  8  accumulator A[7:0]; internal A is 9 bits, A[8] is sign for div.
REQ-009 Q  out  8  multiplier/quotient register.
REQ-010 M  out  8  multiplicand/divisor register.
REQ-011 Q1  out  1  Booth Q[-1] bit.
REQ-012 cs  out  8  control word of current state, combinational from state.
REQ-013 start  out  1  combinational launch strobe.
REQ-014 countBooth / countNRD  out  3 each  iteration counters.
REQ-015 count7Booth / count7NRD  out  1 each  high when the matching counter equals 7.

Function
REQ-016 SHALL hold a register code_q; start = (state==IDLE) && (code != code_q); on a start edge code_q<=code and state<=LOAD.
REQ-017 code changes while not IDLE SHALL be ignored until IDLE is re-entered, then launch via REQ-016.
REQ-018 cs bits: [0] load, [1] A<=A+M, [2] A<=A-M, [3] arith shift right {A,Q,Q1}, [4] shift left {A,Q}, [5] counter increment, [6] Q[0]<=~A[8], [7] write rez/flags.
REQ-019 LOAD (cs=0x01): Q<=X, M<=Y, Q1<=0, counters<=0; A<=X for add/sub, else A<=0; next state by op.
REQ-020 Add/sub: EXEC (cs 0x02 or 0x04) A<=A+M or A-M on 8 bits; DONE: rez<=sign-extended A[7:0]; overflow = signed 8-bit overflow.
REQ-021 Mul: BOOTH_OP: {Q[0],Q1}=01 -> A+=M (cs 0x02); 10 -> A-=M (cs 0x04); 00/11 -> no change (cs 0x00).
REQ-022 Mul: BOOTH_SHIFT (cs 0x28): arithmetic right shift {A,Q,Q1}, countBooth++; if count7Booth -> DONE else BOOTH_OP; DONE: rez<={A,Q}, overflow=0.
REQ-023 Div: if Y==0 at LOAD, go directly to DONE with rez<=16'hFFFF, flag_overflow=1, flag_zero=0.
REQ-024 Div iteration: NRD_SHIFT (cs 0x10) {A,Q}<<=1; NRD_OP: A-=M if A[8]==0 at shift time, else A+=M; NRD_SETQ (cs 0x60) Q[0]<=~A[8], countNRD++, exit after count7NRD.
REQ-025 Div: NRD_CORR state always visited: if A[8] then A+=M (cs 0x02) else cs 0x00; DONE: rez<={A[7:0],Q} (remainder, quotient), overflow=0.
REQ-026 DONE (cs 0x80): writes rez, flag_zero=(rez value==0), flag_overflow; next IDLE. rez/flags hold between DONE writes.
REQ-027 Latency, counted in rising edges after the start edge, until rez is valid: add/sub 3, mul 18, div 27 (div-by-zero 2).
REQ-028 In IDLE cs=0x00; A, Q, M, Q1 and counters hold their values.

Reset
REQ-029 On rst: state<=IDLE, rez<=0, flags<=0, A/Q/M/Q1<=0, counters<=0, code_q<=code; reset mid-operation aborts with no rez write.
REQ-030 While rst is high, start SHALL be 0 and cs SHALL be 0x00.

Verification
REQ-031 rst, then code={8'd10,8'd5,2'b00} -> rez=0x000F after 3 edges, flags 0; code={8'd100,8'd100,00} -> rez=0xFFC8, overflow=1.
REQ-032 code={10,5,01} -> rez=0x0005; code={5,5,01} -> rez=0x0000, flag_zero=1.
REQ-033 code={10,5,10} -> rez=0x0032 after 18 edges, count7Booth seen once; code={8'hFD,5,10} -> rez=0xFFF1.
REQ-034 code={10,5,11} -> rez=0x0002 after 27 edges; code={7,2,11} -> rez=0x0103; code={9,0,11} -> rez=0xFFFF, overflow=1.
REQ-035 Change code mid-multiply -> current result completes unchanged, new op starts from IDLE; rst mid-divide -> all outputs 0, no start until code changes.

Source files
------------

// File: rtl/alu_8bit_if.sv
// Bundle of the ALU's operation code, result, flags and visible datapath/control state.
interface alu_8bit_if;
  logic [17:0] code;
  logic [15:0] rez;
  logic        flag_zero;
  logic        flag_overflow;
  logic [7:0]  A;
  logic [7:0]  Q;
  logic [7:0]  M;
  logic        Q1;
  logic [7:0]  cs;
  logic        start;
  logic [2:0]  countBooth;
  logic [2:0]  countNRD;
  logic        count7Booth;
  logic        count7NRD;

  modport master (
    output code,
    input  rez, flag_zero, flag_overflow, A, Q, M, Q1, cs, start,
           countBooth, countNRD, count7Booth, count7NRD
  );

  modport slave (
    input  code,
    output rez, flag_zero, flag_overflow, A, Q, M, Q1, cs, start,
           countBooth, countNRD, count7Booth, count7NRD
  );
endinterface

// File: rtl/alu_8bit.sv
// Sequential 8-bit ALU: add/sub, signed Booth multiply, unsigned non-restoring divide.
// A new operation launches whenever the idle ALU sees code differ from the last launched code.
module alu_8bit (
  input  logic      clk,
  input  logic      rst,
  alu_8bit_if.slave bus
);
  localparam int unsigned OpW  = 8;
  localparam int unsigned AccW = 9;
  localparam int unsigned RezW = 16;
  localparam int unsigned CntW = 3;
  localparam int unsigned CsW  = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_EXEC, S_BOOTH_OP, S_BOOTH_SHIFT,
    S_NRD_SHIFT, S_NRD_OP, S_NRD_SETQ, S_NRD_CORR, S_DONE
  } state_e;

  state_e          state_q;
  logic [17:0]     code_q;
  logic [AccW-1:0] a_q, a_d;
  logic [OpW-1:0]  q_q, q_d, m_q, m_d;
  logic            q1_q, q1_d;
  logic            sgn_q, sgn_d;
  logic [CntW-1:0] cnt_booth_q, cnt_booth_d, cnt_nrd_q, cnt_nrd_d;
  logic [RezW-1:0] rez_q, rez_d;
  logic            fz_q, fo_q, ovf_d;

  logic [OpW-1:0]  x_c, y_c;
  logic [1:0]      op_c;
  logic [AccW-1:0] m_ext_c;
  logic [CsW-1:0]  cs_c;
  logic            start_c;
  logic            c7_booth_c, c7_nrd_c;

  assign x_c        = code_q[17:10];
  assign y_c        = code_q[9:2];
  assign op_c       = code_q[1:0];
  // Multiply treats M as signed, divide (and add/sub low byte) as unsigned.
  assign m_ext_c    = (op_c == 2'b10) ? {m_q[OpW-1], m_q} : {1'b0, m_q};
  assign c7_booth_c = (cnt_booth_q == 3'd7);
  assign c7_nrd_c   = (cnt_nrd_q == 3'd7);
  assign start_c    = !rst && (state_q == S_IDLE) && (bus.code != code_q);

  // Control word decoded from the current state.
  always_comb begin
    cs_c = '0;
    if (!rst) begin
      unique case (state_q)
        S_LOAD:        cs_c = 8'h01;
        S_EXEC:        cs_c = op_c[0] ? 8'h04 : 8'h02;
        S_BOOTH_OP: begin
          unique case ({q_q[0], q1_q})
            2'b01:   cs_c = 8'h02;
            2'b10:   cs_c = 8'h04;
            default: cs_c = 8'h00;
          endcase
        end
        S_BOOTH_SHIFT: cs_c = 8'h28;
        S_NRD_SHIFT:   cs_c = 8'h10;
        S_NRD_OP:      cs_c = sgn_q ? 8'h02 : 8'h04;
        S_NRD_SETQ:    cs_c = 8'h60;
        S_NRD_CORR:    cs_c = a_q[AccW-1] ? 8'h02 : 8'h00;
        S_DONE:        cs_c = 8'h80;
        default:       cs_c = 8'h00;
      endcase
    end
  end

  // Datapath next values driven by the control word bits.
  always_comb begin
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    q1_d        = q1_q;
    sgn_d       = sgn_q;
    cnt_booth_d = cnt_booth_q;
    cnt_nrd_d   = cnt_nrd_q;
    if (cs_c[0]) begin
      q_d         = x_c;
      m_d         = y_c;
      q1_d        = 1'b0;
      cnt_booth_d = '0;
      cnt_nrd_d   = '0;
      a_d         = op_c[1] ? '0 : {1'b0, x_c};
    end
    if (cs_c[1]) a_d = a_q + m_ext_c;
    if (cs_c[2]) a_d = a_q - m_ext_c;
    if (cs_c[3]) begin
      a_d  = {a_q[AccW-1], a_q[AccW-1:1]};
      q_d  = {a_q[0], q_q[OpW-1:1]};
      q1_d = q_q[0];
    end
    if (cs_c[4]) begin
      {a_d, q_d} = {a_q[AccW-2:0], q_q, 1'b0};
      sgn_d      = a_q[AccW-1];
    end
    if (cs_c[5]) begin
      if (op_c == 2'b10) cnt_booth_d = cnt_booth_q + 3'd1;
      else               cnt_nrd_d   = cnt_nrd_q + 3'd1;
    end
    if (cs_c[6]) q_d[0] = ~a_q[AccW-1];
  end

  // Result and overflow selected by the launched operation.
  always_comb begin
    rez_d = '0;
    ovf_d = 1'b0;
    unique case (op_c)
      2'b00: begin
        rez_d = {{8{a_q[7]}}, a_q[7:0]};
        ovf_d = (q_q[7] == m_q[7]) && (a_q[7] != q_q[7]);
      end
      2'b01: begin
        rez_d = {{8{a_q[7]}}, a_q[7:0]};
        ovf_d = (q_q[7] != m_q[7]) && (a_q[7] != q_q[7]);
      end
      2'b10: rez_d = {a_q[7:0], q_q};
      default: begin
        ovf_d = (m_q == '0);
        rez_d = ovf_d ? 16'hFFFF : {a_q[7:0], q_q};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      code_q      <= bus.code;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      q1_q        <= 1'b0;
      sgn_q       <= 1'b0;
      cnt_booth_q <= '0;
      cnt_nrd_q   <= '0;
      rez_q       <= '0;
      fz_q        <= 1'b0;
      fo_q        <= 1'b0;
    end else begin
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      q1_q        <= q1_d;
      sgn_q       <= sgn_d;
      cnt_booth_q <= cnt_booth_d;
      cnt_nrd_q   <= cnt_nrd_d;
      if (cs_c[7]) begin
        rez_q <= rez_d;
        fz_q  <= (rez_d == '0);
        fo_q  <= ovf_d;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start_c) begin
            code_q  <= bus.code;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          unique case (op_c)
            2'b00, 2'b01: state_q <= S_EXEC;
            2'b10:        state_q <= S_BOOTH_OP;
            default:      state_q <= (y_c == '0) ? S_DONE : S_NRD_SHIFT;
          endcase
        end
        S_EXEC:        state_q <= S_DONE;
        S_BOOTH_OP:    state_q <= S_BOOTH_SHIFT;
        S_BOOTH_SHIFT: state_q <= c7_booth_c ? S_DONE : S_BOOTH_OP;
        S_NRD_SHIFT:   state_q <= S_NRD_OP;
        S_NRD_OP:      state_q <= S_NRD_SETQ;
        S_NRD_SETQ:    state_q <= c7_nrd_c ? S_NRD_CORR : S_NRD_SHIFT;
        S_NRD_CORR:    state_q <= S_DONE;
        S_DONE:        state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rez           = rez_q;
  assign bus.flag_zero     = fz_q;
  assign bus.flag_overflow = fo_q;
  assign bus.A             = a_q[7:0];
  assign bus.Q             = q_q;
  assign bus.M             = m_q;
  assign bus.Q1            = q1_q;
  assign bus.cs            = cs_c;
  assign bus.start         = start_c;
  assign bus.countBooth    = cnt_booth_q;
  assign bus.countNRD      = cnt_nrd_q;
  assign bus.count7Booth   = c7_booth_c;
  assign bus.count7NRD     = c7_nrd_c;
endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vector table, randomized ops vs. reference model,
// and hand-written mid-operation code-change and reset sequences.
module tb_alu_8bit;
  logic clk = 1'b0;
  logic rst;
  alu_8bit_if bus();

  alu_8bit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [1:0]  op;
    logic [15:0] rez;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model from the arithmetic definitions of each operation.
  function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op,
                                output logic [15:0] r, output logic o, output int lat);
    int s;
    logic [7:0] r8;
    o = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        s   = (op == 2'b00) ? int'($signed(x)) + int'($signed(y))
                            : int'($signed(x)) - int'($signed(y));
        r8  = 8'(s);
        r   = {{8{r8[7]}}, r8};
        o   = (s > 127) || (s < -128);
        lat = 3;
      end
      2'b10: begin
        s   = int'($signed(x)) * int'($signed(y));
        r   = 16'(s);
        lat = 18;
      end
      default: begin
        if (y == 8'd0) begin
          r = 16'hFFFF; o = 1'b1; lat = 2;
        end else begin
          r = {8'(x % y), 8'(x / y)}; lat = 27;
        end
      end
    endcase
  endfunction

  // Launch an operation and step exactly lat edges past the start edge; returns count7Booth rises.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op,
                        input int lat, output int rises);
    logic prev;
    prev  = 1'b0;
    rises = 0;
    @(negedge clk);
    bus.code = {x, y, op};
    #1 chk("start_strobe", 32'(bus.start), 32'd1);
    @(posedge clk);
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk);
      #1;
      if (bus.count7Booth && !prev) rises++;
      prev = bus.count7Booth;
      if (e == lat - 1) chk("done_state_cs", 32'(bus.cs), 32'h80);
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] r, input logic z,
                            input logic o, input logic [7:0] y);
    chk({tag, "_rez"}, 32'(bus.rez), 32'(r));
    chk({tag, "_zero"}, 32'(bus.flag_zero), 32'(z));
    chk({tag, "_ovf"}, 32'(bus.flag_overflow), 32'(o));
    chk({tag, "_M"}, 32'(bus.M), 32'(y));
    chk({tag, "_idle_cs"}, 32'(bus.cs), 32'h00);
  endtask

  initial begin
    int rises;
    logic [7:0] x, y;
    logic [1:0] op;
    logic [15:0] er;
    logic eo;
    int lat;

    tbl[0] = '{8'd10,  8'd5,   2'b00, 16'h000F, 1'b0, 1'b0, 3};
    tbl[1] = '{8'd100, 8'd100, 2'b00, 16'hFFC8, 1'b0, 1'b1, 3};
    tbl[2] = '{8'd10,  8'd5,   2'b01, 16'h0005, 1'b0, 1'b0, 3};
    tbl[3] = '{8'd5,   8'd5,   2'b01, 16'h0000, 1'b1, 1'b0, 3};
    tbl[4] = '{8'd10,  8'd5,   2'b10, 16'h0032, 1'b0, 1'b0, 18};
    tbl[5] = '{8'hFD,  8'd5,   2'b10, 16'hFFF1, 1'b0, 1'b0, 18};
    tbl[6] = '{8'd10,  8'd5,   2'b11, 16'h0002, 1'b0, 1'b0, 27};
    tbl[7] = '{8'd7,   8'd2,   2'b11, 16'h0103, 1'b0, 1'b0, 27};
    tbl[8] = '{8'd9,   8'd0,   2'b11, 16'hFFFF, 1'b0, 1'b1, 2};

    rst = 1'b1;
    bus.code = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rez", 32'(bus.rez), 32'd0);
    chk("rst_cs", 32'(bus.cs), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_flags", 32'({bus.flag_zero, bus.flag_overflow}), 32'd0);
    chk("rst_regs", 32'({bus.A, bus.Q, bus.M, bus.Q1}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].lat, rises);
      chk_result($sformatf("vec%0d", i), tbl[i].rez, tbl[i].z, tbl[i].o, tbl[i].y);
      if (tbl[i].op == 2'b10) chk($sformatf("vec%0d_c7booth_rises", i), 32'(rises), 32'd1);
    end

    for (int n = 0; n < 40; n++) begin
      do begin
        x  = 8'($urandom);
        y  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        op = 2'($urandom);
      end while ({x, y, op} == bus.code);
      model(x, y, op, er, eo, lat);
      run_op(x, y, op, lat, rises);
      chk_result($sformatf("rnd%0d", n), er, (er == 16'd0), eo, y);
    end

    // Code change mid-multiply: the running product completes, then the new op launches.
    @(negedge clk);
    bus.code = {8'd3, 8'd4, 2'b10};
    @(posedge clk);
    for (int e = 1; e <= 5; e++) @(posedge clk);
    @(negedge clk);
    bus.code = {8'd20, 8'd3, 2'b00};
    for (int e = 6; e <= 18; e++) @(posedge clk);
    #1;
    chk("midmul_rez", 32'(bus.rez), 32'h000C);
    chk("midmul_relaunch", 32'(bus.start), 32'd1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("midmul_next_rez", 32'(bus.rez), 32'h0017);

    // Reset mid-divide aborts the operation and clears all visible state.
    @(negedge clk);
    bus.code = {8'd200, 8'd7, 2'b11};
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstdiv_cs_comb", 32'(bus.cs), 32'd0);
    chk("rstdiv_start_comb", 32'(bus.start), 32'd0);
    @(posedge clk);
    #1;
    chk("rstdiv_rez", 32'(bus.rez), 32'd0);
    chk("rstdiv_regs", 32'({bus.A, bus.Q, bus.M, bus.Q1}), 32'd0);
    chk("rstdiv_cnts", 32'({bus.countBooth, bus.countNRD, bus.count7Booth, bus.count7NRD}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstdiv_no_start", 32'(bus.start), 32'd0);
    chk("rstdiv_rez_held", 32'(bus.rez), 32'd0);
    run_op(8'd200, 8'd6, 2'b11, 27, rises);
    chk_result("post_rst_div", 16'h0221, 1'b0, 1'b0, 8'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
